// File: rtl/glitcher_pkg.sv
// Shared definitions for the glitcher clock/reset infrastructure:
// reset-sequencer state encoding and default timing parameters.
package glitcher_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    STAGGER   = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  localparam int unsigned DEFAULT_STABLE_CYCLES  = 1024;
  localparam int unsigned DEFAULT_STAGGER_CYCLES = 16;
  localparam logic [7:0]  LOSS_COUNT_MAX         = 8'hFF;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage single-bit synchronizer with asynchronous active-low clear.
// Also used for external trigger inputs.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // NOTE: clocked state is written with non-blocking assignments so every
  // stage samples the value its predecessor held before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// Holds core and glitch-engine resets until PLL lock has been stable, releases
// them in order, and records lock losses that occur after release.
module pll_reset_seq
  import glitcher_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = DEFAULT_STABLE_CYCLES,
  parameter int unsigned STAGGER_CYCLES = DEFAULT_STAGGER_CYCLES,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       locked,
  input  logic       clear_lost,
  output logic       core_reset_n,
  output logic       glitch_reset_n,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] loss_count
);

  localparam int unsigned CNT_W = $clog2(max_u(STABLE_CYCLES, STAGGER_CYCLES) + 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);

  logic              locked_s;
  seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              core_q, core_d;
  logic              glitch_q, glitch_d;
  logic              ready_q, ready_d;
  logic              lost_q, lost_d;
  logic [7:0]        loss_cnt_q, loss_cnt_d;
  logic              loss;

  sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clock_in),
    .rst_n (reset_n),
    .d_i   (locked),
    .q_o   (locked_s)
  );

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lost_d     = lost_q;
    loss_cnt_d = loss_cnt_q;
    loss       = 1'b0;

    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (locked_s) state_d = STABLE;
      end
      STABLE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = STAGGER;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STAGGER: begin
        if (!locked_s) begin
          loss = 1'b1;
        end else if (cnt_q == STAGGER_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!locked_s) loss = 1'b1;
      end
      default: state_d = WAIT_LOCK;
    endcase

    if (loss) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
    end

    // A clear applied with a loss on the same edge still records that loss.
    if (clear_lost) begin
      lost_d     = 1'b0;
      loss_cnt_d = '0;
    end
    if (loss) begin
      lost_d     = 1'b1;
      loss_cnt_d = (loss_cnt_d == LOSS_COUNT_MAX) ? loss_cnt_d : loss_cnt_d + 8'd1;
    end

    core_d   = (state_d == STAGGER) || (state_d == RUN);
    glitch_d = (state_d == RUN);
    ready_d  = (state_d == RUN);
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= WAIT_LOCK;
      cnt_q      <= '0;
      core_q     <= 1'b0;
      glitch_q   <= 1'b0;
      ready_q    <= 1'b0;
      lost_q     <= 1'b0;
      loss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      core_q     <= core_d;
      glitch_q   <= glitch_d;
      ready_q    <= ready_d;
      lost_q     <= lost_d;
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign core_reset_n   = core_q;
  assign glitch_reset_n = glitch_q;
  assign ready          = ready_q;
  assign lock_lost      = lost_q;
  assign loss_count     = loss_cnt_q;

endmodule
